// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the command-sequence checker.
package cmd_seq_pkg;

  localparam logic [7:0] ACK     = 8'h5A;
  localparam logic [7:0] POS_ACK = 8'hA5;

  localparam int CMD_W   = 16;
  localparam int NRESP_W = 2;
  localparam int ENTRY_W = CMD_W + NRESP_W;

  typedef enum logic [2:0] {NONE, TMO_SENT, TMO_RESP, BAD_ACK, UNEXP, OVF} err_t;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, DONE, FAIL} state_t;

  // A zero response count is treated as a single response.
  function automatic logic [NRESP_W-1:0] norm_nresp(input logic [NRESP_W-1:0] n);
    return (n == '0) ? NRESP_W'(1) : n;
  endfunction

endpackage

// File: rtl/cmd_seq_checker_if.sv
// UART-side handshake between the sequence checker (master) and the UART wrapper (slave).
interface cmd_seq_checker_if;
  import cmd_seq_pkg::*;

  logic [CMD_W-1:0] cmd;
  logic             send_cmd;
  logic             cmd_sent;
  logic             resp_rdy;
  logic [7:0]       resp;

  modport master (output cmd, send_cmd, input cmd_sent, resp_rdy, resp);
  modport slave  (input cmd, send_cmd, output cmd_sent, resp_rdy, resp);

endinterface

// File: rtl/cmd_fifo.sv
// Command queue: DEPTH x W first-word-fall-through FIFO with synchronous flush.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok, pop_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on a full queue still lands.
  assign push_ok = push && (!full || pop_ok) && !flush;
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cmd_seq_checker.sv
// Runs a queue of commands over a UART wrapper and checks each ACK/POS_ACK reply.
// Optional response counter enabled by defining CMD_SEQ_CHK_STATS_EN.
module cmd_seq_checker
  import cmd_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TMO_W = 24
) (
  input  logic                     clk,
  input  logic                     RST_n,
  input  logic                     push,
  input  logic [CMD_W-1:0]         push_cmd,
  input  logic [NRESP_W-1:0]       push_nresp,
  input  logic [TMO_W-1:0]         tmo_clks,
  input  logic                     start,
  input  logic                     clr,
  cmd_seq_checker_if.master        uart,
  output logic                     full,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output err_t                     err_code,
  output logic [$clog2(DEPTH)-1:0] err_idx,
  output logic [15:0]              resp_cnt
);

  localparam int IW = $clog2(DEPTH);

  state_t               state_q, state_d;
  err_t                 err_q, err_d, fail_err;
  logic [CMD_W-1:0]     cmd_q, cmd_d;
  logic [NRESP_W-1:0]   rem_q, rem_d;
  logic [IW-1:0]        idx_q, idx_d, cur_idx_q, cur_idx_d, err_idx_q, err_idx_d;
  logic [TMO_W-1:0]     timer_q, timer_d, tmo_q, tmo_d;
  logic                 send_q, send_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                 fifo_pop, fifo_empty, fifo_full;
  logic [ENTRY_W-1:0]   fifo_rdata;
  logic                 tmo_hit, resp_ok, fail, ovf;

  cmd_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (RST_n),
    .flush (clr),
    .push  (push),
    .wdata ({push_cmd, push_nresp}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Expiry fires on the cycle the counter would reach tmo_clks.
  assign tmo_hit = ({1'b0, timer_q} + 1'b1) >= {1'b0, tmo_q};
  assign ovf     = push && fifo_full && !fifo_pop && !clr;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    cur_idx_d = cur_idx_q;
    err_idx_d = err_idx_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    fifo_pop  = 1'b0;
    resp_ok   = 1'b0;
    fail      = 1'b0;
    fail_err  = NONE;

    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_d   = LOAD;
          tmo_d     = tmo_clks;
          idx_d     = '0;
          cur_idx_d = '0;
          err_idx_d = '0;
          err_d     = NONE;
        end
      end
      LOAD: begin
        if (uart.resp_rdy) begin
          fail     = 1'b1;
          fail_err = UNEXP;
        end else if (fifo_empty) begin
          state_d = DONE;
        end else begin
          fifo_pop  = 1'b1;
          cmd_d     = fifo_rdata[ENTRY_W-1:NRESP_W];
          rem_d     = norm_nresp(fifo_rdata[NRESP_W-1:0]);
          cur_idx_d = idx_q;
          idx_d     = idx_q + 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (uart.resp_rdy) begin
          fail     = 1'b1;
          fail_err = UNEXP;
        end else begin
          state_d = WAIT_SENT;
        end
      end
      WAIT_SENT: begin
        if (uart.resp_rdy) begin
          fail     = 1'b1;
          fail_err = UNEXP;
        end else if (uart.cmd_sent) begin
          state_d = WAIT_RESP;
        end else if (tmo_hit) begin
          fail     = 1'b1;
          fail_err = TMO_SENT;
        end
      end
      WAIT_RESP: begin
        if (uart.resp_rdy) begin
          if (uart.resp == ((rem_q == NRESP_W'(1)) ? POS_ACK : ACK)) begin
            resp_ok = 1'b1;
            if (rem_q == NRESP_W'(1)) state_d = fifo_empty ? DONE : LOAD;
            else                      rem_d   = rem_q - 1'b1;
          end else begin
            fail     = 1'b1;
            fail_err = BAD_ACK;
          end
        end else if (tmo_hit) begin
          fail     = 1'b1;
          fail_err = TMO_RESP;
        end
      end
      default: ;
    endcase

    if (fail) begin
      state_d   = FAIL;
      err_d     = fail_err;
      err_idx_d = cur_idx_q;
    end
    // Overflow is sticky and outranks any sequence failure code until clr.
    if (ovf || err_q == OVF) err_d = OVF;

    if (clr) begin
      state_d   = IDLE;
      cmd_d     = '0;
      rem_d     = '0;
      idx_d     = '0;
      cur_idx_d = '0;
      err_idx_d = '0;
      err_d     = NONE;
    end

    if (state_d != state_q || resp_ok)                 timer_d = '0;
    else if (state_q == WAIT_SENT || state_q == WAIT_RESP) timer_d = timer_q + 1'b1;
    else                                               timer_d = '0;

    send_d = (state_d == SEND);
    busy_d = (state_d inside {LOAD, SEND, WAIT_SENT, WAIT_RESP});
    done_d = (state_d inside {DONE, FAIL});
    pass_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= IDLE;
      err_q     <= NONE;
      cmd_q     <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      cur_idx_q <= '0;
      err_idx_q <= '0;
      timer_q   <= '0;
      tmo_q     <= '0;
      send_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      cmd_q     <= cmd_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      cur_idx_q <= cur_idx_d;
      err_idx_q <= err_idx_d;
      timer_q   <= timer_d;
      tmo_q     <= tmo_d;
      send_q    <= send_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

`ifdef CMD_SEQ_CHK_STATS_EN
  logic [15:0] resp_cnt_q, resp_cnt_d;

  always_comb begin
    resp_cnt_d = resp_cnt_q;
    if (clr)                                   resp_cnt_d = '0;
    else if (resp_ok && resp_cnt_q != 16'hFFFF) resp_cnt_d = resp_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) resp_cnt_q <= '0;
    else        resp_cnt_q <= resp_cnt_d;
  end

  assign resp_cnt = resp_cnt_q;
`else
  assign resp_cnt = '0;
`endif

  assign uart.cmd      = cmd_q;
  assign uart.send_cmd = send_q;
  assign full          = fifo_full;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_code      = err_q;
  assign err_idx       = err_idx_q;

endmodule

// File: tb/tb_cmd_seq_checker.sv
// Directed bench for cmd_seq_checker with hand-computed expectations.
module tb_cmd_seq_checker;
  import cmd_seq_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO_W = 24;
`ifdef CMD_SEQ_CHK_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic              clk = 1'b0;
  logic              RST_n;
  logic              push;
  logic [15:0]       push_cmd;
  logic [1:0]        push_nresp;
  logic [TMO_W-1:0]  tmo_clks;
  logic              start;
  logic              clr;
  logic              full, busy, done, pass;
  err_t              err_code;
  logic [2:0]        err_idx;
  logic [15:0]       resp_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  cmd_seq_checker_if u_if ();

  cmd_seq_checker #(.DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
    .clk        (clk),
    .RST_n      (RST_n),
    .push       (push),
    .push_cmd   (push_cmd),
    .push_nresp (push_nresp),
    .tmo_clks   (tmo_clks),
    .start      (start),
    .clr        (clr),
    .uart       (u_if),
    .full       (full),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_code   (err_code),
    .err_idx    (err_idx),
    .resp_cnt   (resp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] c, input logic [1:0] n);
    push = 1'b1; push_cmd = c; push_nresp = n;
    step();
    push = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_send(input string tag);
    int n = 0;
    while (u_if.send_cmd !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk(tag, 32'(u_if.send_cmd), 1);
  endtask

  task automatic sent();
    u_if.cmd_sent = 1'b1;
    step();
    u_if.cmd_sent = 1'b0;
  endtask

  task automatic give_resp(input logic [7:0] b);
    u_if.resp_rdy = 1'b1; u_if.resp = b;
    step();
    u_if.resp_rdy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST_n = 1'b1; push = 1'b0; push_cmd = '0; push_nresp = '0; tmo_clks = 24'd60000;
    start = 1'b0; clr = 1'b0;
    u_if.cmd_sent = 1'b0; u_if.resp_rdy = 1'b0; u_if.resp = '0;
    #2 RST_n = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_code), 32'(NONE));
    chk("rst_cmd", 32'(u_if.cmd), 0);
    chk("rst_send", 32'(u_if.send_cmd), 0);
    chk("rst_full", 32'(full), 0);
    RST_n = 1'b1;
    step();

    // Three single-response entries, all acknowledged with POS_ACK.
    for (int i = 0; i < 3; i++) push_one(16'h1001 + 16'(i), 2'd1);
    do_start();
    chk("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      wait_send("t1_send");
      chk("t1_cmd", 32'(u_if.cmd), 32'h1001 + 32'(i));
      step();
      chk("t1_strobe_len", 32'(u_if.send_cmd), 0);
      sent();
      give_resp(POS_ACK);
    end
    chk("t1_done", 32'(done), 1);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_err", 32'(err_code), 32'(NONE));
    chk("t1_resp_cnt", 32'(resp_cnt), (STATS != 0) ? 3 : 0);

    // Two-response entry: ACK then POS_ACK passes.
    do_clr();
    chk("clr_resp_cnt", 32'(resp_cnt), 0);
    push_one(16'h2002, 2'd2);
    do_start();
    wait_send("t2a_send");
    step(); sent();
    give_resp(ACK);
    chk("t2a_mid_busy", 32'(busy), 1);
    chk("t2a_mid_done", 32'(done), 0);
    give_resp(POS_ACK);
    chk("t2a_done", 32'(done), 1);
    chk("t2a_pass", 32'(pass), 1);

    // Two-response entry: POS_ACK first is a bad ack.
    do_clr();
    push_one(16'h2003, 2'd2);
    do_start();
    wait_send("t2b_send");
    step(); sent();
    give_resp(POS_ACK);
    chk("t2b_done", 32'(done), 1);
    chk("t2b_pass", 32'(pass), 0);
    chk("t2b_err", 32'(err_code), 32'(BAD_ACK));
    chk("t2b_idx", 32'(err_idx), 0);

    // Second entry fails: index must point at entry 1.
    do_clr();
    push_one(16'h3001, 2'd1);
    push_one(16'h3002, 2'd1);
    do_start();
    wait_send("t2c_send0");
    step(); sent(); give_resp(POS_ACK);
    wait_send("t2c_send1");
    chk("t2c_cmd1", 32'(u_if.cmd), 32'h3002);
    step(); sent(); give_resp(ACK);
    chk("t2c_err", 32'(err_code), 32'(BAD_ACK));
    chk("t2c_idx", 32'(err_idx), 1);

    // nresp = 0 behaves as a single response.
    do_clr();
    push_one(16'h3003, 2'd0);
    do_start();
    wait_send("t2d_send");
    step(); sent(); give_resp(POS_ACK);
    chk("t2d_pass", 32'(pass), 1);

    // Transmit timeout: fail exactly 100 clocks after entering WAIT_SENT.
    do_clr();
    tmo_clks = 24'd100;
    push_one(16'h5001, 2'd1);
    do_start();
    wait_send("t3_send");
    repeat (100) step();
    chk("t3_before_tmo", 32'(done), 0);
    step();
    chk("t3_done", 32'(done), 1);
    chk("t3_pass", 32'(pass), 0);
    chk("t3_err", 32'(err_code), 32'(TMO_SENT));

    // cmd_sent on the expiry cycle wins over the timeout.
    do_clr();
    push_one(16'h5002, 2'd1);
    do_start();
    wait_send("t3b_send");
    repeat (100) step();
    sent();
    chk("t3b_no_fail", 32'(done), 0);
    chk("t3b_busy", 32'(busy), 1);
    give_resp(POS_ACK);
    chk("t3b_pass", 32'(pass), 1);

    // Response timeout with tmo_clks = 10.
    do_clr();
    tmo_clks = 24'd10;
    push_one(16'h5003, 2'd1);
    do_start();
    wait_send("t3c_send");
    step(); sent();
    repeat (9) step();
    chk("t3c_before_tmo", 32'(done), 0);
    step();
    chk("t3c_err", 32'(err_code), 32'(TMO_RESP));

    // resp_rdy while idle is ignored; while waiting for cmd_sent it is unexpected.
    do_clr();
    tmo_clks = 24'd60000;
    give_resp(POS_ACK);
    chk("t4_idle_done", 32'(done), 0);
    chk("t4_idle_err", 32'(err_code), 32'(NONE));
    push_one(16'h6001, 2'd1);
    do_start();
    wait_send("t4_send");
    step();
    give_resp(POS_ACK);
    chk("t4_done", 32'(done), 1);
    chk("t4_err", 32'(err_code), 32'(UNEXP));

    // Overflow: DEPTH+1 pushes, the last is dropped.
    do_clr();
    for (int i = 0; i < DEPTH; i++) push_one(16'h4000 + 16'(i), 2'd1);
    chk("t5_full", 32'(full), 1);
    chk("t5_err_pre", 32'(err_code), 32'(NONE));
    push_one(16'h4008, 2'd1);
    chk("t5_full_ovf", 32'(full), 1);
    chk("t5_err_ovf", 32'(err_code), 32'(OVF));
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      wait_send("t5_send");
      chk("t5_cmd", 32'(u_if.cmd), 32'h4000 + 32'(i));
      step(); sent(); give_resp(POS_ACK);
    end
    chk("t5_done", 32'(done), 1);
    chk("t5_pass", 32'(pass), 1);
    chk("t5_err_sticky", 32'(err_code), 32'(OVF));
    do_clr();
    chk("t5_clr_full", 32'(full), 0);
    chk("t5_clr_err", 32'(err_code), 32'(NONE));

    // Push on a full queue in the same cycle as the pop is accepted.
    for (int i = 0; i < DEPTH; i++) push_one(16'h7000 + 16'(i), 2'd1);
    do_start();
    push_one(16'h7777, 2'd1);
    chk("t6_pp_err", 32'(err_code), 32'(NONE));
    chk("t6_pp_full", 32'(full), 1);

    // clr wins over start and push; then an empty-queue start.
    do_clr();
    push_one(16'h8001, 2'd1);
    clr = 1'b1; start = 1'b1; push = 1'b1; push_cmd = 16'h8002; push_nresp = 2'd1;
    step();
    clr = 1'b0; start = 1'b0; push = 1'b0;
    chk("t7_clr_busy", 32'(busy), 0);
    chk("t7_clr_full", 32'(full), 0);
    do_start();
    chk("t7_empty_1cyc", 32'(done), 0);
    step();
    chk("t7_empty_done", 32'(done), 1);
    chk("t7_empty_pass", 32'(pass), 1);

    // Asynchronous reset in WAIT_RESP.
    do_clr();
    push_one(16'h9001, 2'd1);
    do_start();
    wait_send("t8_send");
    step(); sent();
    RST_n = 1'b0;
    #1;
    chk("t8_busy", 32'(busy), 0);
    chk("t8_done", 32'(done), 0);
    chk("t8_pass", 32'(pass), 0);
    chk("t8_cmd", 32'(u_if.cmd), 0);
    chk("t8_send", 32'(u_if.send_cmd), 0);
    chk("t8_err", 32'(err_code), 32'(NONE));
    chk("t8_idx", 32'(err_idx), 0);
    chk("t8_resp_cnt", 32'(resp_cnt), 0);
    repeat (2) step();
    RST_n = 1'b1;
    repeat (3) step();
    chk("t8_post_send", 32'(u_if.send_cmd), 0);
    chk("t8_post_busy", 32'(busy), 0);
    chk("t8_post_full", 32'(full), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cmd_seq_checker.md
CMD_SEQ_CHECKER -- requirements
Module: cmd_seq_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning command-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter TMO_W, default 24, meaning timeout counter width in bits.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all state on rising edge.
REQ-004 SHALL have port RST_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port push  input  1  enqueue one entry this cycle.
REQ-006 SHALL have port push_cmd  input  16  command word of entry.
REQ-007 SHALL have port push_nresp  input  2  expected responses for entry, 1..3; a value of 0 is treated as 1.
REQ-008 SHALL have port tmo_clks  input  TMO_W  per-wait timeout in clocks, sampled at start.
REQ-009 SHALL have port start  input  1  begin executing the queue.
REQ-010 SHALL have port clr  input  1  synchronous soft clear.
REQ-011 SHALL have port cmd  output  16  command presented to the UART wrapper.
REQ-012 SHALL have port send_cmd  output  1  one-cycle transmit strobe.
REQ-013 SHALL have port cmd_sent  input  1  transmit complete.
REQ-014 SHALL have port resp_rdy  input  1  response byte valid (one-cycle pulse).
REQ-015 SHALL have port resp  input  8  response byte.
REQ-016 SHALL have port full  output  1  queue full.
REQ-017 SHALL have port busy  output  1  sequence running.
REQ-018 SHALL have port done  output  1  sequence ended; sticky.
REQ-019 SHALL have port pass  output  1  valid only with done.
REQ-020 SHALL have port err_code  output  err_t  failure reason.
REQ-021 SHALL have port err_idx  output  $clog2(DEPTH)  index of the failing entry.
REQ-022 SHALL have port resp_cnt  output  16  total responses accepted.

Function
REQ-023 SHALL implement FSM states IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, DONE, FAIL.
REQ-024 SHALL go IDLE->LOAD on start; with the queue empty it SHALL go to DONE in the next cycle with pass=1.
REQ-025 LOAD SHALL pop the head entry into cmd, load the remaining-response count, and increment the entry index.
REQ-026 SHALL go LOAD->SEND; SEND SHALL assert send_cmd for exactly one cycle, then go to WAIT_SENT.
REQ-027 SHALL go WAIT_SENT->WAIT_RESP on cmd_sent; SHALL go to FAIL with err=TMO_SENT when the counter reaches tmo_clks.
REQ-028 In WAIT_RESP, each resp_rdy SHALL reload the timer and decrement the remaining count; a non-final response SHALL equal ACK (8'h5A) and the final response SHALL equal POS_ACK (8'hA5), otherwise go to FAIL with err=BAD_ACK.
REQ-029 After the final response, SHALL go to LOAD when the queue is non-empty, else to DONE with pass=1.
REQ-030 SHALL go to FAIL with err=TMO_RESP when no response arrives within tmo_clks.
REQ-031 The timer SHALL clear on every state entry; an event and timer expiry in the same cycle SHALL resolve to the event.
REQ-032 resp_rdy outside WAIT_RESP while busy SHALL go to FAIL with err=UNEXP; resp_rdy while idle SHALL be ignored.
REQ-033 FAIL SHALL set done=1, pass=0, and latch err_idx; DONE and FAIL SHALL hold until clr or start.
REQ-034 push SHALL be allowed in any state; push when full SHALL be dropped and set err OVF, sticky until clr; a simultaneous push and pop on a full queue SHALL be accepted.
REQ-035 busy SHALL be 1 in LOAD through WAIT_RESP.
REQ-036 start while busy SHALL be ignored.
REQ-037 clr SHALL empty the queue, return to IDLE, and zero all status and resp_cnt; clr SHALL win over start and push.

Reset
REQ-038 On RST_n low: state=IDLE, queue empty, cmd=16'h0000, send_cmd=0, busy=0, done=0, pass=0, err_code=NONE, err_idx=0, resp_cnt=0, timer=0.
REQ-039 RST_n asserted mid-sequence SHALL abort immediately, with no residual strobe after release.

Configuration
REQ-040 Macro CMD_SEQ_CHK_STATS_EN defined: resp_cnt SHALL increment (saturating at 16'hFFFF) on every accepted resp_rdy.
REQ-041 Macro CMD_SEQ_CHK_STATS_EN undefined: resp_cnt SHALL be tied to 0 and its counter SHALL not be built.

Structure
REQ-042 Package cmd_seq_pkg SHALL hold ACK=8'h5A, POS_ACK=8'hA5, typedef err_t {NONE, TMO_SENT, TMO_RESP, BAD_ACK, UNEXP, OVF}, and the state enum.
REQ-043 The queue SHALL be sub-module cmd_fifo, parametrised on DEPTH and an 18-bit entry width (cmd and nresp).

Verification
REQ-044 Push 3 entries with nresp=1, tmo_clks=60000, start; the model acks each with A5 -> three send_cmd pulses, done=1, pass=1, resp_cnt=3.
REQ-045 Push one entry with nresp=2; the model returns 5A then A5 -> pass=1; returning A5 then A5 instead -> FAIL, BAD_ACK, err_idx=0.
REQ-046 Hold cmd_sent low with tmo_clks=100 -> FAIL with TMO_SENT exactly 100 clocks after WAIT_SENT entry; cmd_sent on the expiry cycle -> no fail.
REQ-047 Push DEPTH+1 entries while idle -> full=1, the last entry is dropped, err OVF; a subsequent clr leaves full=0 and err NONE.
REQ-048 Start with an empty queue -> done=1 and pass=1 two cycles later; RST_n low during WAIT_RESP -> all outputs at reset values.
